// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - architectural NZCV flag register with condition-code evaluator
// Results sit in a single-entry buffer with a valid/ack handshake and a saturating pass counter.
module flag_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aluN,
  input  logic             aluZ,
  input  logic             aluC,
  input  logic             aluV,
  input  logic [1:0]       aluOp,
  input  logic             flagWrEn,
  input  logic             flagLoad,
  input  logic [3:0]       flagLoadData,
  input  logic             condReq,
  input  logic [3:0]       condCode,
  output logic             condReady,
  output logic             condValid,
  output logic             condPass,
  input  logic             condAck,
  output logic [3:0]       flags,
  output logic             carryOut,
  output logic [CNT_W-1:0] passCnt
);

  logic [3:0] flags_next;
  logic       eval_pass;
  logic       accept;
  logic       n_f, z_f, c_f, v_f;

  // Restore wins over ALU commit; logical ops leave C/V untouched, rotate leaves V.
  always_comb begin
    flags_next = flags;
    if (flagLoad) begin
      flags_next = flagLoadData;
    end else if (flagWrEn) begin
      case (aluOp)
        2'b00, 2'b01: flags_next = {aluN, aluZ, aluC, aluV};
        2'b10:        flags_next = {aluN, aluZ, flags[1:0]};
        default:      flags_next = {aluN, aluZ, aluC, flags[0]};
      endcase
    end
  end

  // Evaluate against the forwarded flags so a same-cycle update is visible.
  assign {n_f, z_f, c_f, v_f} = flags_next;

  always_comb begin
    eval_pass = 1'b0;
    case (condCode)
      4'h0: eval_pass = z_f;
      4'h1: eval_pass = !z_f;
      4'h2: eval_pass = c_f;
      4'h3: eval_pass = !c_f;
      4'h4: eval_pass = n_f;
      4'h5: eval_pass = !n_f;
      4'h6: eval_pass = v_f;
      4'h7: eval_pass = !v_f;
      4'h8: eval_pass = c_f && !z_f;
      4'h9: eval_pass = !c_f || z_f;
      4'hA: eval_pass = (n_f == v_f);
      4'hB: eval_pass = (n_f != v_f);
      4'hC: eval_pass = !z_f && (n_f == v_f);
      4'hD: eval_pass = z_f || (n_f != v_f);
      4'hE: eval_pass = 1'b1;
      default: eval_pass = 1'b0;
    endcase
  end

  assign condReady = !condValid || condAck;
  assign accept    = condReq && condReady;
  assign carryOut  = flags[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= 4'b0000;
      condValid <= 1'b0;
      condPass  <= 1'b0;
      passCnt   <= '0;
    end else begin
      flags <= flags_next;
      if (accept) begin
        condValid <= 1'b1;
        condPass  <= eval_pass;
        if (eval_pass && (passCnt != {CNT_W{1'b1}}))
          passCnt <= passCnt + CNT_W'(1);
      end else if (condAck) begin
        condValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// tb/tb_flag_cond_unit.sv - table-driven and scoreboard bench for flag_cond_unit
// Built with a 2-bit pass counter so saturation is reachable quickly.
module tb_flag_cond_unit;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             aluN, aluZ, aluC, aluV;
  logic [1:0]       aluOp;
  logic             flagWrEn, flagLoad;
  logic [3:0]       flagLoadData;
  logic             condReq;
  logic [3:0]       condCode;
  logic             condReady, condValid, condPass, condAck;
  logic [3:0]       flags;
  logic             carryOut;
  logic [CNT_W-1:0] passCnt;

  flag_cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV), .aluOp(aluOp),
    .flagWrEn(flagWrEn), .flagLoad(flagLoad), .flagLoadData(flagLoadData),
    .condReq(condReq), .condCode(condCode), .condReady(condReady),
    .condValid(condValid), .condPass(condPass), .condAck(condAck),
    .flags(flags), .carryOut(carryOut), .passCnt(passCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] ldd;
    logic       we;
    logic [1:0] op;
    logic [3:0] nzcv;
    logic       rq;
    logic [3:0] cc;
    logic       ak;
    logic [3:0] ef;
    logic       ep;
  } vec_t;

  vec_t tbl[$];
  logic exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic       mvalid, mpass;
  logic [1:0] mcnt;

  function automatic vec_t mk(logic ld, logic [3:0] ldd, logic we, logic [1:0] op,
                              logic [3:0] nzcv, logic rq, logic [3:0] cc, logic ak,
                              logic [3:0] ef, logic ep);
    vec_t v;
    v.ld = ld; v.ldd = ldd; v.we = we; v.op = op; v.nzcv = nzcv;
    v.rq = rq; v.cc = cc; v.ak = ak; v.ef = ef; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic rq_during);
    reset = 1'b1;
    flagWrEn = rq_during; aluOp = 2'b00; {aluN, aluZ, aluC, aluV} = 4'b1111;
    condReq = rq_during; condCode = 4'hE; condAck = 1'b0; flagLoad = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    flagWrEn = 1'b0; condReq = 1'b0;
    mvalid = 1'b0; mpass = 1'b0; mcnt = 2'd0;
    exp_q.delete();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_carry", carryOut, 1'b0);
    chk("rst_valid", condValid, 1'b0);
    chk("rst_pass", condPass, 1'b0);
    chk("rst_cnt", passCnt, 0);
    #1;
    chk("rst_ready", condReady, 1'b1);
  endtask

  // One cycle: drive, check ready, step the reference model, then check after the edge.
  task automatic drive(input vec_t v);
    logic exp_rdy, acc, e;
    flagLoad = v.ld; flagLoadData = v.ldd; flagWrEn = v.we; aluOp = v.op;
    {aluN, aluZ, aluC, aluV} = v.nzcv;
    condReq = v.rq; condCode = v.cc; condAck = v.ak;
    #1;
    exp_rdy = !mvalid || v.ak;
    chk("ready", condReady, exp_rdy);
    acc = v.rq && exp_rdy;
    if (acc) begin
      exp_q.push_back(v.ep);
      mpass = v.ep;
      mvalid = 1'b1;
      if (v.ep && mcnt != 2'd3) mcnt = mcnt + 2'd1;
    end else if (v.ak) begin
      mvalid = 1'b0;
    end
    @(posedge clk); #1;
    flagLoad = 1'b0; flagWrEn = 1'b0; condReq = 1'b0; condAck = 1'b0;
    chk("flags", flags, v.ef);
    chk("carry", carryOut, v.ef[1]);
    chk("valid", condValid, mvalid);
    if (acc) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_pass", condPass, e);
      end
    end
    chk("pass_hold", condPass, mpass);
    chk("cnt", passCnt, mcnt);
  endtask

  logic [3:0] cur_flags;
  logic [1:0] cnt_exp [5];

  initial begin
    reset = 1'b1; aluN = 0; aluZ = 0; aluC = 0; aluV = 0; aluOp = 0;
    flagWrEn = 0; flagLoad = 0; flagLoadData = 0; condReq = 0; condCode = 0; condAck = 0;
    do_reset(1'b0);

    //        ld ldd     we op     nzcv    rq cc    ak  flags   pass
    tbl.push_back(mk(0, 4'h0, 1, 2'b00, 4'b0110, 1, 4'h2, 1, 4'b0110, 1));
    tbl.push_back(mk(1, 4'hF, 1, 2'b00, 4'b0000, 1, 4'h9, 1, 4'b1111, 1));
    tbl.push_back(mk(0, 4'h0, 1, 2'b10, 4'b0000, 1, 4'h4, 1, 4'b0011, 0));
    tbl.push_back(mk(1, 4'hF, 0, 2'b00, 4'b0000, 1, 4'h0, 1, 4'b1111, 1));
    tbl.push_back(mk(0, 4'h0, 1, 2'b11, 4'b0000, 1, 4'h6, 1, 4'b0001, 1));
    tbl.push_back(mk(1, 4'h0, 0, 2'b00, 4'b0000, 0, 4'h0, 1, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h0, 1, 2'b00, 4'b0100, 1, 4'h0, 1, 4'b0100, 1));
    tbl.push_back(mk(1, 4'h9, 1, 2'b00, 4'b0110, 1, 4'hA, 1, 4'b1001, 1));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hB, 1, 4'b1001, 0));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hF, 1, 4'b1001, 0));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hC, 1, 4'b1001, 1));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hD, 1, 4'b1001, 0));
    tbl.push_back(mk(0, 4'h0, 1, 2'b01, 4'b0010, 1, 4'h8, 1, 4'b0010, 1));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'h3, 1, 4'b0010, 0));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'h1, 1, 4'b0010, 1));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'h5, 1, 4'b0010, 1));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'h7, 1, 4'b0010, 1));
    tbl.push_back(mk(1, 4'h0, 0, 2'b00, 4'b0000, 0, 4'h0, 1, 4'b0000, 0));
    tbl.push_back(mk(0, 4'h0, 1, 2'b11, 4'b1011, 1, 4'hB, 1, 4'b1010, 1));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'h9, 1, 4'b1010, 0));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 0, 4'h0, 0, 4'b1010, 0));
    tbl.push_back(mk(0, 4'h0, 0, 2'b00, 4'b0000, 0, 4'h0, 1, 4'b1010, 0));

    foreach (tbl[i]) drive(tbl[i]);

    // Stalled consumer: result and counter hold, ready low, then ack+request swaps in the new result.
    do_reset(1'b0);
    drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hE, 0, 4'b0000, 1));
    for (int k = 0; k < 3; k++) begin
      drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hF, 0, 4'b0000, 0));
      chk("stall_pass", condPass, 1'b1);
      chk("stall_cnt", passCnt, 1);
    end
    drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hF, 1, 4'b0000, 0));
    chk("swap_valid", condValid, 1'b1);
    chk("swap_pass", condPass, 1'b0);
    drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hE, 1, 4'b0000, 1));
    drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 0, 4'h0, 1, 4'b0000, 0));
    chk("ack_clear", condValid, 1'b0);

    // Counter saturation at 3 with a 2-bit counter.
    do_reset(1'b0);
    cnt_exp[0] = 2'd1; cnt_exp[1] = 2'd2; cnt_exp[2] = 2'd3; cnt_exp[3] = 2'd3; cnt_exp[4] = 2'd3;
    for (int k = 0; k < 5; k++) begin
      drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hE, 1, 4'b0000, 1));
      chk("sat_cnt", passCnt, cnt_exp[k]);
    end
    drive(mk(0, 4'h0, 0, 2'b00, 4'b0000, 1, 4'hE, 0, 4'b0000, 1));
    chk("pre_rst_valid", condValid, 1'b1);

    // Reset beats a simultaneous flag write and request, and drops the pending result.
    do_reset(1'b1);
    cur_flags = 4'b0101;
    drive(mk(0, 4'h0, 1, 2'b00, cur_flags, 0, 4'h0, 0, cur_flags, 0));
    chk("post_rst_cnt", passCnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
